wb_mem_responder: RTL and testbench

Wishbone classic-cycle responder that answers the Amber core's 128-bit instruction/data bus as synthesizable memory. It replaces the bench's forcing of `i_wb_dat`/`i_wb_ack` with a real slave:

- decodes the core's `cyc`/`stb` requests;
- inserts a programmable number of wait states;
- performs byte-lane writes from the 16-bit select;
- returns read data with a single-cycle `ack`, or `err` for out-of-range addresses.

A side-band preload port lets the bench fill instruction/data words before or during a run.

---
 rtl/wb_resp_pkg.sv | 24 ++
 rtl/wb_resp_mem.sv | 60 ++++++
 rtl/wb_mem_responder.sv | 153 +++++++++++++++
 tb/tb_wb_mem_responder.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_resp_pkg.sv
// Shared widths, state encoding and address-range helper for the Wishbone
// memory responder.
package wb_resp_pkg;

   localparam int WB_DATA_W = 128;
   localparam int WB_SEL_W  = 16;
   localparam int WB_ADR_W  = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } wb_resp_state_t;

   // Offset-based compare avoids overflow of base + depth*16 near the top of the address space.
   function automatic logic in_range(input logic [WB_ADR_W-1:0] adr,
                                     input logic [WB_ADR_W-1:0] base,
                                     input int unsigned depth);
      logic [WB_ADR_W-1:0] offset;
      offset = adr - base;
      return (adr >= base) && (offset < WB_ADR_W'(depth * 16));
   endfunction

endpackage

// File: rtl/wb_resp_mem.sv
// DEPTH x 128-bit word store: byte-lane bus write, whole-word preload that
// overrides a same-index bus write, and a registered read port that idles at 0.
module wb_resp_mem
   import wb_resp_pkg::*;
#(
   parameter int DEPTH = 256
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_en,
   input  logic [$clog2(DEPTH)-1:0]   wr_idx,
   input  logic [WB_SEL_W-1:0]        wr_sel,
   input  logic [WB_DATA_W-1:0]       wr_dat,
   input  logic                       ld_en,
   input  logic [$clog2(DEPTH)-1:0]   ld_idx,
   input  logic [WB_DATA_W-1:0]       ld_dat,
   input  logic                       rd_en,
   input  logic [$clog2(DEPTH)-1:0]   rd_idx,
   output logic [WB_DATA_W-1:0]       rd_dat
);

   logic [WB_DATA_W-1:0] mem_q [DEPTH];
   logic [WB_DATA_W-1:0] rd_dat_q;
   logic [WB_DATA_W-1:0] rd_dat_d;
   logic                 wr_blocked;

   assign wr_blocked = ld_en && (ld_idx == wr_idx);

   // Storage is deliberately left unreset.
   always_ff @(posedge clk) begin
      if (wr_en && !wr_blocked) begin
         for (int k = 0; k < WB_SEL_W; k++) begin
            if (wr_sel[k]) begin
               mem_q[wr_idx][8*k +: 8] <= wr_dat[8*k +: 8];
            end
         end
      end
      if (ld_en) begin
         mem_q[ld_idx] <= ld_dat;
      end
   end

   always_comb begin
      rd_dat_d = '0;
      if (rd_en) begin
         rd_dat_d = mem_q[rd_idx];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_dat_q <= '0;
      end else begin
         rd_dat_q <= rd_dat_d;
      end
   end

   assign rd_dat = rd_dat_q;

endmodule

// File: rtl/wb_mem_responder.sv
// Wishbone classic-cycle memory slave: request capture, programmable wait
// states, address decode and single-cycle ack/err response.
module wb_mem_responder
   import wb_resp_pkg::*;
#(
   parameter int                   DEPTH       = 256,
   parameter int                   WAIT_STATES = 1,
   parameter logic [WB_ADR_W-1:0]  BASE_ADR    = 32'h0000_0000
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic [WB_ADR_W-1:0]       i_wb_adr,
   input  logic [WB_SEL_W-1:0]       i_wb_sel,
   input  logic                      i_wb_we,
   input  logic [WB_DATA_W-1:0]      i_wb_dat,
   input  logic                      i_wb_cyc,
   input  logic                      i_wb_stb,
   output logic [WB_DATA_W-1:0]      o_wb_dat,
   output logic                      o_wb_ack,
   output logic                      o_wb_err,
   input  logic                      i_load_en,
   input  logic [$clog2(DEPTH)-1:0]  i_load_idx,
   input  logic [WB_DATA_W-1:0]      i_load_dat,
   output logic                      o_busy
);

   localparam int         IDX_W     = $clog2(DEPTH);
   localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   wb_resp_state_t        state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [WB_ADR_W-1:0]   adr_q, adr_d;
   logic [WB_SEL_W-1:0]   sel_q, sel_d;
   logic                  we_q, we_d;
   logic [WB_DATA_W-1:0]  dat_q, dat_d;
   logic                  ack_q, ack_d;
   logic                  err_q, err_d;

   logic [WB_ADR_W-1:0]   req_adr;
   logic [WB_SEL_W-1:0]   req_sel;
   logic                  req_we;
   logic [WB_DATA_W-1:0]  req_dat;
   logic [IDX_W-1:0]      req_idx;
   logic                  req_hit;
   logic                  commit;

   // With zero wait states the commit happens on the sampling edge, so it must use the live bus.
   always_comb begin
      req_adr = adr_q;
      req_sel = sel_q;
      req_we  = we_q;
      req_dat = dat_q;
      if (state_q == IDLE) begin
         req_adr = i_wb_adr;
         req_sel = i_wb_sel;
         req_we  = i_wb_we;
         req_dat = i_wb_dat;
      end
      req_hit = in_range(req_adr, BASE_ADR, DEPTH);
      req_idx = IDX_W'((req_adr - BASE_ADR) >> 4);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      adr_d   = adr_q;
      sel_d   = sel_q;
      we_d    = we_q;
      dat_d   = dat_q;
      commit  = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_wb_cyc && i_wb_stb) begin
               adr_d = i_wb_adr;
               sel_d = i_wb_sel;
               we_d  = i_wb_we;
               dat_d = i_wb_dat;
               if (WAIT_STATES == 0) begin
                  state_d = RESP;
                  commit  = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = WAIT_INIT;
               end
            end
         end
         WAIT: begin
            if (!i_wb_cyc) begin
               state_d = IDLE;
               cnt_d   = 4'd0;
            end else if (cnt_q == 4'd0) begin
               state_d = RESP;
               commit  = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end
      endcase
      ack_d = commit && req_hit;
      err_d = commit && !req_hit;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         adr_q   <= '0;
         sel_q   <= '0;
         we_q    <= 1'b0;
         dat_q   <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         adr_q   <= adr_d;
         sel_q   <= sel_d;
         we_q    <= we_d;
         dat_q   <= dat_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   wb_resp_mem #(
      .DEPTH (DEPTH)
   ) u_mem (
      .clk    (i_clk),
      .rst_n  (i_rst_n),
      .wr_en  (commit && req_hit && req_we),
      .wr_idx (req_idx),
      .wr_sel (req_sel),
      .wr_dat (req_dat),
      .ld_en  (i_load_en),
      .ld_idx (i_load_idx),
      .ld_dat (i_load_dat),
      .rd_en  (commit && req_hit && !req_we),
      .rd_idx (req_idx),
      .rd_dat (o_wb_dat)
   );

   assign o_wb_ack = ack_q;
   assign o_wb_err = err_q;
   assign o_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_wb_mem_responder.sv
// Drives three responders (0, 1 and 3 wait states) with one shared bus and
// compares each against a transaction-timeline model plus literal expectations.
module tb_wb_mem_responder;

   localparam int NI = 3;

   localparam logic [127:0] W3   = 128'hF0801003_F0801003_F0801003_E3A01005;
   localparam logic [127:0] ONES = {128{1'b1}};
   localparam logic [127:0] PL5  = 128'h0123456789ABCDEF_FEDCBA9876543210;
   localparam logic [127:0] WD5  = 128'hCAFEBABE_DEADBEEF_0BADF00D_12345678;

   function automatic int ws_of(input int g);
      case (g)
         0:       return 0;
         1:       return 1;
         default: return 3;
      endcase
   endfunction

   logic          clk = 1'b0;
   logic          rst_n;
   logic [31:0]   adr;
   logic [15:0]   sel;
   logic          we;
   logic [127:0]  wdat;
   logic          cyc;
   logic          stb;
   logic          load_en;
   logic [7:0]    load_idx;
   logic [127:0]  load_dat;

   logic [127:0]  dat_o  [NI];
   logic          ack_o  [NI];
   logic          err_o  [NI];
   logic          busy_o [NI];

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   genvar g;
   generate
      for (g = 0; g < NI; g++) begin : g_dut
         localparam int WS = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
         wb_mem_responder #(
            .DEPTH       (256),
            .WAIT_STATES (WS),
            .BASE_ADR    (32'h0000_0000)
         ) u_dut (
            .i_clk      (clk),
            .i_rst_n    (rst_n),
            .i_wb_adr   (adr),
            .i_wb_sel   (sel),
            .i_wb_we    (we),
            .i_wb_dat   (wdat),
            .i_wb_cyc   (cyc),
            .i_wb_stb   (stb),
            .o_wb_dat   (dat_o[g]),
            .o_wb_ack   (ack_o[g]),
            .o_wb_err   (err_o[g]),
            .i_load_en  (load_en),
            .i_load_idx (load_idx),
            .i_load_dat (load_dat),
            .o_busy     (busy_o[g])
         );
      end
   endgenerate

   task automatic checkOutput(input string name, input logic [130:0] got, input logic [130:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Model: a transaction accepted at edge N completes at edge N+WS unless cyc is low at a later edge.
   int unsigned   edge_n = 0;
   bit            pend    [NI];
   int unsigned   due     [NI];
   logic [31:0]   p_adr   [NI];
   logic [15:0]   p_sel   [NI];
   logic          p_we    [NI];
   logic [127:0]  p_dat   [NI];
   bit            resp_v  [NI];
   logic          exp_ack [NI];
   logic          exp_err [NI];
   logic          exp_busy[NI];
   logic [127:0]  exp_dat [NI];
   logic [127:0]  mem_m   [NI][256];

   task automatic modelClear();
      for (int i = 0; i < NI; i++) begin
         pend[i] = 0; resp_v[i] = 0;
         exp_ack[i] = 0; exp_err[i] = 0; exp_busy[i] = 0; exp_dat[i] = '0;
      end
   endtask

   task automatic modelCommit(input int i, input logic [31:0] a, input logic w,
                              input logic [15:0] s, input logic [127:0] d);
      int idx;
      resp_v[i] = 1;
      if (a >= 32'h1000) begin
         exp_err[i] = 1'b1;
         return;
      end
      idx = int'(a >> 4);
      exp_ack[i] = 1'b1;
      if (w) begin
         if (!(load_en && (int'(load_idx) == idx))) begin
            for (int k = 0; k < 16; k++) begin
               if (s[k]) mem_m[i][idx][8*k +: 8] = d[8*k +: 8];
            end
         end
      end else begin
         exp_dat[i] = mem_m[i][idx];
      end
   endtask

   initial begin
      bit was_resp;
      modelClear();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            modelClear();
         end else begin
            edge_n++;
            for (int i = 0; i < NI; i++) begin
               was_resp   = resp_v[i];
               resp_v[i]  = 0;
               exp_ack[i] = 0; exp_err[i] = 0; exp_dat[i] = '0;
               if (pend[i]) begin
                  if (!cyc) begin
                     pend[i] = 0;
                  end else if (edge_n == due[i]) begin
                     pend[i] = 0;
                     modelCommit(i, p_adr[i], p_we[i], p_sel[i], p_dat[i]);
                  end
               end else if (!was_resp && cyc && stb) begin
                  if (ws_of(i) == 0) begin
                     modelCommit(i, adr, we, sel, wdat);
                  end else begin
                     pend[i]  = 1;
                     due[i]   = edge_n + ws_of(i);
                     p_adr[i] = adr; p_sel[i] = sel; p_we[i] = we; p_dat[i] = wdat;
                  end
               end
               if (load_en) mem_m[i][load_idx] = load_dat;
               exp_busy[i] = pend[i] || resp_v[i];
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
               checkOutput($sformatf("model_g%0d_t%0t", i, $time),
                           {ack_o[i], err_o[i], busy_o[i], dat_o[i]},
                           {exp_ack[i], exp_err[i], exp_busy[i], exp_dat[i]});
            end
         end
      end
   end

   logic          gotAck [NI];
   logic          gotErr [NI];
   logic [127:0]  gotDat [NI];

   // One strobe, cyc held until every instance has responded; captures each response in its ack cycle.
   task automatic applyStimulus(input logic [31:0] a, input logic w, input logic [15:0] s, input logic [127:0] d);
      adr = a; we = w; sel = s; wdat = d; cyc = 1'b1; stb = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (k == 0) stb = 1'b0;
         for (int i = 0; i < NI; i++) begin
            if (ws_of(i) == k) begin
               gotAck[i] = ack_o[i]; gotErr[i] = err_o[i]; gotDat[i] = dat_o[i];
            end
         end
         if (k == 3) cyc = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic checkXfer(input string name, input logic ea, input logic ee, input logic [127:0] ed);
      for (int i = 0; i < NI; i++) begin
         checkOutput($sformatf("%s_g%0d", name, i), {gotAck[i], gotErr[i], 1'b0, gotDat[i]}, {ea, ee, 1'b0, ed});
      end
   endtask

   task automatic preload(input logic [7:0] idx, input logic [127:0] d);
      load_en = 1'b1; load_idx = idx; load_dat = d;
      @(negedge clk);
      load_en = 1'b0;
   endtask

   logic       sawResp [NI];
   logic [5:0] pat     [NI];

   initial begin
      rst_n = 1'b0; adr = '0; sel = '0; we = 1'b0; wdat = '0; cyc = 1'b0; stb = 1'b0;
      load_en = 1'b0; load_idx = '0; load_dat = '0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < NI; i++)
         checkOutput($sformatf("reset_g%0d", i), {ack_o[i], err_o[i], busy_o[i], dat_o[i]}, 131'd0);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      @(negedge clk);

      preload(8'd3, W3);
      applyStimulus(32'h30, 1'b0, 16'h0000, '0);
      checkXfer("rd_preload", 1'b1, 1'b0, W3);

      preload(8'd0, '0);
      applyStimulus(32'h0, 1'b1, 16'h000F, ONES);
      checkXfer("wr_lanes", 1'b1, 1'b0, '0);
      applyStimulus(32'h0, 1'b0, 16'h0000, '0);
      checkXfer("rd_lanes", 1'b1, 1'b0, 128'h00000000_00000000_00000000_FFFFFFFF);

      applyStimulus(32'h1000, 1'b0, 16'h0000, '0);
      checkXfer("rd_oor", 1'b0, 1'b1, '0);
      applyStimulus(32'h1000, 1'b1, 16'hFFFF, {4{32'hAAAAAAAA}});
      checkXfer("wr_oor", 1'b0, 1'b1, '0);
      applyStimulus(32'h0, 1'b0, 16'h0000, '0);
      checkXfer("rd_after_oor", 1'b1, 1'b0, 128'h00000000_00000000_00000000_FFFFFFFF);

      // Abort: cyc drops one cycle after the request; only the zero-wait instance has already committed.
      preload(8'd4, {4{32'h11111111}});
      adr = 32'h40; we = 1'b1; sel = 16'hFFFF; wdat = {4{32'h22222222}}; cyc = 1'b1; stb = 1'b1;
      for (int i = 0; i < NI; i++) sawResp[i] = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         cyc = 1'b0; stb = 1'b0;
         for (int i = 0; i < NI; i++) sawResp[i] = sawResp[i] | ack_o[i] | err_o[i];
      end
      for (int i = 0; i < NI; i++) begin
         checkOutput($sformatf("abort_resp_g%0d", i), 131'(sawResp[i]), 131'(i == 0));
         checkOutput($sformatf("abort_busy_g%0d", i), 131'(busy_o[i]), 131'd0);
      end
      applyStimulus(32'h40, 1'b0, 16'h0000, '0);
      checkOutput("abort_word_g0", 131'(gotDat[0]), 131'({4{32'h22222222}}));
      checkOutput("abort_word_g1", 131'(gotDat[1]), 131'({4{32'h11111111}}));
      checkOutput("abort_word_g2", 131'(gotDat[2]), 131'({4{32'h11111111}}));

      adr = 32'h30; we = 1'b0; sel = '0; wdat = '0; cyc = 1'b1; stb = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         for (int i = 0; i < NI; i++) pat[i][k] = ack_o[i];
         if (k == 5) begin cyc = 1'b0; stb = 1'b0; end
      end
      repeat (3) @(negedge clk);
      checkOutput("b2b_g0", 131'(pat[0]), 131'(6'b010101));
      checkOutput("b2b_g1", 131'(pat[1]), 131'(6'b010010));
      checkOutput("b2b_g2", 131'(pat[2]), 131'(6'b001000));

      // Preload held across every commit edge so each instance sees the collision.
      load_en = 1'b1; load_idx = 8'd5; load_dat = PL5;
      applyStimulus(32'h50, 1'b1, 16'hFFFF, WD5);
      load_en = 1'b0;
      checkXfer("wr_collide", 1'b1, 1'b0, '0);
      applyStimulus(32'h50, 1'b0, 16'h0000, '0);
      checkXfer("rd_collide", 1'b1, 1'b0, PL5);
      applyStimulus(32'h50, 1'b1, 16'hFF00, {4{32'h5A5A5A5A}});
      applyStimulus(32'h50, 1'b0, 16'h0000, '0);
      checkXfer("rd_upper_lanes", 1'b1, 1'b0, 128'h5A5A5A5A5A5A5A5A_FEDCBA9876543210);

      adr = 32'h30; we = 1'b0; sel = '0; cyc = 1'b1; stb = 1'b1;
      @(negedge clk);
      stb = 1'b0;
      @(negedge clk);
      checkOutput("pre_reset_ack_g1", {ack_o[1], err_o[1], busy_o[1], dat_o[1]}, {3'b101, W3});
      #2;
      rst_n = 1'b0; cyc = 1'b0;
      #1;
      for (int i = 0; i < NI; i++)
         checkOutput($sformatf("reset_async_g%0d", i), {ack_o[i], err_o[i], busy_o[i], dat_o[i]}, 131'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < NI; i++)
         checkOutput($sformatf("reset_release_g%0d", i), {ack_o[i], err_o[i], busy_o[i], dat_o[i]}, 131'd0);
      @(negedge clk);
      applyStimulus(32'h30, 1'b0, 16'h0000, '0);
      checkXfer("rd_after_reset", 1'b1, 1'b0, W3);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      errors++;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
